dac_spi_multi: RTL and testbench
================================

// Module: dac_spi_multi
// PURPOSE
//  Parametrised multi-channel serial-DAC driver (DAC7311 class, SYNC/SCLK/DIN) behind the byte-wide
//  register bus. CHANNELS DACs share SCLK/DIN, each has its own SYNC. Committed words are queued as
//  pending and sent round-robin, MSB first. Sits beside the other byte-bus peripherals.
// PARAMETERS
//  CHANNELS   2   DACs driven, 1..7 (the status byte limits this)
//  WORD_BITS  16  bits per frame, 8..32
//  CLK_DIV    4   i_clk cycles per SCLK period; even, >=2 (odd is an elaboration error)
//  SYNC_GAP   4   minimum i_clk cycles SYNC stays high between frames, >=1
//  BYTES      ceil(WORD_BITS/8), derived: register bytes per channel
//  ADDR_W     clog2(CHANNELS*BYTES+1), derived: address width
// PORTS
//  i_clk         in   1         system clock (50 MHz)
//  i_rst         in   1         synchronous reset, active high
//  i_wr_n        in   1         bus write strobe, active low, one cycle per byte
//  i_addr        in   ADDR_W    byte address
//  i_data        in   8         write data
//  o_data        out  8         read data, combinational on i_addr
//  o_busy        out  1         frame or LDAC pulse in progress
//  o_dac_sync_n  out  CHANNELS  per-DAC frame select, active low
//  o_dac_clk     out  1         shared SCLK, idles high
//  o_dac_data    out  1         shared DIN
//  o_dac_ldac_n  out  1         shared load strobe, active low (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (sampled on i_clk): sync_n all 1, dac_clk 1, dac_data 0, busy 0, ldac_n 1. Also clears
//    words, shadows and pending, and sets rr pointer to 0. Reset mid-frame aborts on the next edge.
//  - Map: addr = ch*BYTES + b, b=0 is the LS byte. Bytes b<BYTES-1 go to the shadow only.
//    - Writing b=BYTES-1 commits {data,shadow} to word[ch] and sets pending[ch] in the same cycle.
//    - Addr CHANNELS*BYTES = STATUS (read-only): {busy, 0.., pending[CHANNELS-1:0]}.
//    - Reads return committed word bytes. Writes to STATUS or higher are ignored; reads there return 0.
//  - FSM IDLE -> LOAD -> SHIFT -> GAP -> [LDAC] -> IDLE; all outputs registered.
//  - IDLE: if any pending, pick the lowest ch >= rr (wrapping), then go to LOAD.
//  - LOAD (1 cycle): latch word[ch] into the shift register, clear pending[ch], set rr=ch+1 mod CHANNELS.
//    A write committed in the same cycle re-sets pending (set wins over clear).
//  - SHIFT: starts the cycle after LOAD.
//    - sync_n[ch]=0 for exactly WORD_BITS*CLK_DIV cycles.
//    - Per bit: dac_data = next MSB-first bit, clk high CLK_DIV/2 cycles, then low CLK_DIV/2 cycles.
//    - Data changes only with the clk rising edge; the DAC samples on the falling edge.
//  - GAP: sync_n all 1, clk 1, for SYNC_GAP cycles. The next frame's sync_n fall is >= SYNC_GAP+1
//    cycles after the previous rise.
//  - Writes during a frame never alter the bits in flight; a rewritten channel goes out in a later frame.
//  - o_busy=1 from LOAD through the end of GAP/LDAC. Back-to-back pending frames keep busy high.
//  - Frame latency: from a commit in IDLE to the sync_n fall = 2 cycles.
//  - Unlisted bits of the word above WORD_BITS are ignored. Bus writes are accepted in every state.
// CONFIGURATION
//  - DAC_SPI_LDAC_EN defined:
//    - After GAP, if no channel is pending, enter LDAC: ldac_n=0 for CLK_DIV cycles, then IDLE.
//    - If any channel is pending after GAP, go straight to LOAD; LDAC is deferred until the queue drains.
//  - DAC_SPI_LDAC_EN undefined: no LDAC state; o_dac_ldac_n tied 1; GAP -> IDLE.
// TESTING (defaults: CHANNELS=2, WORD_BITS=16, CLK_DIV=4, SYNC_GAP=4)
//  - Reset: pulse i_rst 2 cycles -> sync_n=2'b11, clk=1, data=0, busy=0, ldac_n=1; STATUS read = 0x00.
//  - Single write: addr0<=0x34, addr1<=0x12 -> sync_n[0] low 64 cycles, 16 falling edges capture
//    0x1234 MSB first; sync_n[1] stays 1; STATUS=0x00 after GAP.
//  - Arbitration: commit ch1=0x5555 then ch0=0xAAAA on consecutive cycles -> ch1 frame first (already
//    in LOAD), then ch0. Second sync_n fall >= 5 cycles after the first rise; STATUS mid-first = 0x81.
//  - Rewrite in flight: write ch0=0xABCD at bit 5 of a 0x1234 frame -> frame completes 0x1234, next
//    frame sends 0xABCD; no third frame.
//  - Abort/ignore: i_rst at bit 8 -> next edge idle outputs, no further frames. A write to addr 5
//    changes nothing; read of addr 5 = 0x00.
//  - LDAC (macro on): queue ch0 and ch1 -> one ldac_n low pulse of 4 cycles, only after the second
//    GAP. Macro off: ldac_n constant 1.

Source files
------------

// File: rtl/dac_spi_multi.sv
// Round-robin SYNC/SCLK/DIN driver for CHANNELS serial DACs behind the byte bus.
// Define DAC_SPI_LDAC_EN to add a shared LDAC pulse once the frame queue drains.
module dac_spi_multi #(
    parameter int  CHANNELS  = 2,
    parameter int  WORD_BITS = 16,
    parameter int  CLK_DIV   = 4,
    parameter int  SYNC_GAP  = 4,
    localparam int BYTES     = (WORD_BITS + 7) / 8,
    localparam int ADDR_W    = $clog2(CHANNELS * BYTES + 1)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_wr_n,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [7:0]          i_data,
    output logic [7:0]          o_data,
    output logic                o_busy,
    output logic [CHANNELS-1:0] o_dac_sync_n,
    output logic                o_dac_clk,
    output logic                o_dac_data,
    output logic                o_dac_ldac_n
);
    localparam int NBYTES = CHANNELS * BYTES;
    localparam int CW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int SW     = (BYTES > 1) ? (BYTES - 1) * 8 : 8;
    localparam int WW     = BYTES * 8;
    localparam int HALF   = CLK_DIV / 2;
    localparam int TW     = 16;

    if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
        $error("CLK_DIV must be even and >= 2");
    end

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, GAP, LDAC} state_t;

    logic [WW-1:0]       word_q   [CHANNELS];
    logic [SW-1:0]       shadow_q [CHANNELS];
    logic [CHANNELS-1:0] pending_q;
    logic [CHANNELS-1:0] set_mask;
    logic [CHANNELS-1:0] clr_mask;
    logic [WW-1:0]       commit_word;
    logic [WW-1:0]       ld_word;
    logic [7:0]          status;
    logic                addr_ok;
    logic                wr_ok;
    logic                commit;
    logic [CW-1:0]       a_ch;
    int                  a_b;

    state_t              state_q, state_d;
    logic [CW-1:0]       ch_q, ch_d;
    logic [CW-1:0]       rr_q, rr_d;
    logic [CW-1:0]       pick;
    logic [CW-1:0]       pick_idx;
    logic [WORD_BITS-2:0] sr_q, sr_d;
    logic [TW-1:0]       cnt_q, cnt_d;
    logic [5:0]          bit_q, bit_d;
    logic [CHANNELS-1:0] sync_n_q, sync_n_d;
    logic                clk_q, clk_d;
    logic                data_q, data_d;
    logic                busy_q, busy_d;
`ifdef DAC_SPI_LDAC_EN
    logic                ldac_n_q, ldac_n_d;
`endif

    always_comb begin
        addr_ok = int'(i_addr) < NBYTES;
        a_ch    = '0;
        a_b     = 0;
        if (addr_ok) begin
            a_ch = CW'(int'(i_addr) / BYTES);
            a_b  = int'(i_addr) % BYTES;
        end
        wr_ok    = !i_wr_n && addr_ok;
        commit   = wr_ok && (a_b == BYTES - 1);
        set_mask = '0;
        if (commit) set_mask[a_ch] = 1'b1;
        status    = 8'(pending_q);
        status[7] = busy_q;
        o_data    = 8'h00;
        if (addr_ok) o_data = word_q[a_ch][a_b*8 +: 8];
        else if (int'(i_addr) == NBYTES) o_data = status;
    end

    if (BYTES > 1) begin : g_shadow
        always_comb commit_word = {i_data, shadow_q[a_ch]};
    end else begin : g_no_shadow
        always_comb commit_word = i_data;
    end

    // Descending scan so the smallest offset from rr is the last to win.
    always_comb begin
        pick     = rr_q;
        pick_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            pick_idx = CW'((int'(rr_q) + i) % CHANNELS);
            if (pending_q[pick_idx]) pick = pick_idx;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pending_q <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                word_q[c]   <= '0;
                shadow_q[c] <= '0;
            end
        end else begin
            pending_q <= (pending_q & ~clr_mask) | set_mask;
            if (commit) word_q[a_ch] <= commit_word;
            else if (wr_ok) shadow_q[a_ch][a_b*8 +: 8] <= i_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        rr_d     = rr_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        sync_n_d = sync_n_q;
        clk_d    = clk_q;
        data_d   = data_q;
        busy_d   = busy_q;
        clr_mask = '0;
        ld_word  = word_q[ch_q];
`ifdef DAC_SPI_LDAC_EN
        ldac_n_d = 1'b1;
`endif
        unique case (state_q)
            IDLE: begin
                busy_d = |pending_q;
                if (|pending_q) begin
                    state_d = LOAD;
                    ch_d    = pick;
                end
            end
            LOAD: begin
                state_d        = SHIFT;
                sr_d           = ld_word[WORD_BITS-2:0];
                clr_mask[ch_q] = 1'b1;
                rr_d     = (ch_q == CW'(CHANNELS - 1)) ? '0 : ch_q + 1'b1;
                cnt_d    = '0;
                bit_d    = '0;
                sync_n_d = ~(CHANNELS'(1) << ch_q);
                clk_d    = 1'b1;
                data_d   = ld_word[WORD_BITS-1];
            end
            SHIFT: begin
                if (cnt_q == TW'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    clk_d = 1'b1;
                    if (bit_q == 6'(WORD_BITS - 1)) begin
                        state_d  = GAP;
                        sync_n_d = '1;
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        sr_d   = sr_q << 1;
                        data_d = sr_q[WORD_BITS-2];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    clk_d = (cnt_q + 1'b1) < TW'(HALF);
                end
            end
            GAP: begin
                if (cnt_q == TW'(SYNC_GAP - 1)) begin
                    cnt_d = '0;
`ifdef DAC_SPI_LDAC_EN
                    if (|pending_q) begin
                        state_d = LOAD;
                        ch_d    = pick;
                    end else begin
                        state_d  = LDAC;
                        ldac_n_d = 1'b0;
                    end
`else
                    state_d = IDLE;
                    busy_d  = |pending_q;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef DAC_SPI_LDAC_EN
            LDAC: begin
                if (cnt_q == TW'(CLK_DIV - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = |pending_q;
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                    ldac_n_d = 1'b0;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            rr_q     <= '0;
            sr_q     <= '0;
            cnt_q    <= '0;
            bit_q    <= '0;
            sync_n_q <= '1;
            clk_q    <= 1'b1;
            data_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef DAC_SPI_LDAC_EN
            ldac_n_q <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            rr_q     <= rr_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            sync_n_q <= sync_n_d;
            clk_q    <= clk_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
`ifdef DAC_SPI_LDAC_EN
            ldac_n_q <= ldac_n_d;
`endif
        end
    end

    assign o_busy       = busy_q;
    assign o_dac_sync_n = sync_n_q;
    assign o_dac_clk    = clk_q;
    assign o_dac_data   = data_q;
`ifdef DAC_SPI_LDAC_EN
    assign o_dac_ldac_n = ldac_n_q;
`else
    assign o_dac_ldac_n = 1'b1;
`endif

endmodule

// File: tb/tb_dac_spi_multi.sv
// Bench for dac_spi_multi: pin-level frame capture against a queue-based model.
// Frames are decoded from SYNC/SCLK/DIN and compared with the expected send order.
module tb_dac_spi_multi;
    localparam int CH   = 2;
    localparam int WB   = 16;
    localparam int DIV  = 4;
    localparam int GAPC = 4;
    localparam int AW   = 3;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          wr_n  = 1'b1;
    logic [AW-1:0] addr  = '0;
    logic [7:0]    wdata = '0;
    logic [7:0]    rdata;
    logic          busy;
    logic [CH-1:0] sync_n;
    logic          dclk;
    logic          ddata;
    logic          ldac_n;

    dac_spi_multi #(
        .CHANNELS(CH), .WORD_BITS(WB), .CLK_DIV(DIV), .SYNC_GAP(GAPC)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_wr_n(wr_n), .i_addr(addr),
        .i_data(wdata), .o_data(rdata), .o_busy(busy),
        .o_dac_sync_n(sync_n), .o_dac_clk(dclk), .o_dac_data(ddata),
        .o_dac_ldac_n(ldac_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        logic [31:0] val;
        int          nf;
        int          lowc;
    } frame_t;

    frame_t frames[$];
    int     gaps[$];
    int     pulses[$];
    int     pulse_done[$];
    int     pulse_dist[$];
    int     cyc = 0;
    int     last_rise = -1;
    int     frames_done = 0;
    int     dviol = 0;
    int     multi = 0;
    int     n_checks = 0;
    int     n_errs = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pin monitor: decodes frames on SCLK falling edges, mid-cycle sampling.
    initial begin
        logic          in_f;
        int            fch, fnf, flow, lcnt;
        logic [31:0]   fval;
        logic [CH-1:0] p_sync;
        logic          p_clk, p_data, p_ldac;
        in_f = 0; fch = 0; fnf = 0; flow = 0; lcnt = 0; fval = 0;
        p_sync = '1; p_clk = 1; p_data = 0; p_ldac = 1;
        forever begin
            @(negedge clk);
            cyc++;
            if (!in_f) begin
                for (int c = 0; c < CH; c++) begin
                    if (!in_f && p_sync[c] === 1'b1 && sync_n[c] === 1'b0) begin
                        in_f = 1; fch = c; fval = 0; fnf = 0; flow = 0;
                        if (last_rise >= 0) gaps.push_back(cyc - last_rise);
                    end
                end
            end
            if (in_f) begin
                if (sync_n[fch] === 1'b0) begin
                    flow++;
                    if (p_clk === 1'b1 && dclk === 1'b0) begin
                        fval = {fval[30:0], ddata};
                        fnf++;
                    end
                    if (flow > 1 && ddata !== p_data && !(dclk === 1'b1 && p_clk === 1'b0))
                        dviol++;
                end else begin
                    frames.push_back('{fch, fval, fnf, flow});
                    frames_done++;
                    in_f = 0;
                    last_rise = cyc;
                end
            end
            if ($countones(~sync_n) > 1) multi++;
            if (ldac_n === 1'b0) begin
                if (p_ldac === 1'b1) begin
                    pulse_done.push_back(frames_done);
                    pulse_dist.push_back(cyc - last_rise);
                end
                lcnt++;
            end else if (p_ldac === 1'b0) begin
                pulses.push_back(lcnt);
                lcnt = 0;
            end
            p_sync = sync_n; p_clk = dclk; p_data = ddata; p_ldac = ldac_n;
        end
    end

    task automatic wr(input int a, input logic [7:0] d);
        @(negedge clk);
        addr = AW'(a); wdata = d; wr_n = 1'b0;
        @(posedge clk);
        #1 wr_n = 1'b1;
    endtask

    task automatic rd(input int a, output logic [7:0] d);
        @(negedge clk);
        addr = AW'(a);
        #1 d = rdata;
    endtask

    task automatic wr_word(input int ch, input logic [15:0] v);
        wr(ch * 2, v[7:0]);
        wr(ch * 2 + 1, v[15:8]);
    endtask

    task automatic wait_idle();
        int quiet, n;
        quiet = 0; n = 0;
        repeat (3) @(negedge clk);
        while (quiet < 4 && n < 3000) begin
            @(negedge clk);
            n++;
            quiet = (busy === 1'b0) ? quiet + 1 : 0;
        end
        if (n >= 3000) check("idle_timeout", n, 0);
    endtask

    task automatic clear_logs();
        frames.delete(); gaps.delete();
        pulses.delete(); pulse_done.delete(); pulse_dist.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  r;
        frame_t      f;
        int          base, sel, first, bad;
        int          exp_ch[$];
        logic [15:0] v[CH];

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_sync", sync_n, 2'b11);
        check("rst_clk", dclk, 1'b1);
        check("rst_data", ddata, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ldac", ldac_n, 1'b1);
        rd(4, r);
        check("rst_status", r, 8'h00);

        clear_logs();
        wr_word(0, 16'h1234);
        wait_idle();
        check("single_n", frames.size(), 1);
        if (frames.size() > 0) begin
            f = frames[0];
            check("single_ch", f.ch, 0);
            check("single_val", f.val, 32'h1234);
            check("single_falls", f.nf, 16);
            check("single_low", f.lowc, WB * DIV);
        end
        rd(4, r);
        check("single_status", r, 8'h00);
        rd(1, r);
        check("single_rb", r, 8'h12);

        clear_logs();
        wr(2, 8'h55);
        wr(0, 8'hAA);
        wr(3, 8'h55);
        wr(1, 8'hAA);
        repeat (20) @(negedge clk);
        rd(4, r);
        check("arb_status", r, 8'h81);
        wait_idle();
        check("arb_n", frames.size(), 2);
        if (frames.size() == 2) begin
            check("arb_ch0", frames[0].ch, 1);
            check("arb_v0", frames[0].val, 32'h5555);
            check("arb_ch1", frames[1].ch, 0);
            check("arb_v1", frames[1].val, 32'hAAAA);
        end
        if (gaps.size() > 0)
            check("arb_gap", gaps[gaps.size()-1] >= GAPC + 1, 1'b1);

        clear_logs();
        wr_word(0, 16'h1234);
        repeat (21) @(posedge clk);
        wr_word(0, 16'hABCD);
        wait_idle();
        check("rew_n", frames.size(), 2);
        if (frames.size() == 2) begin
            check("rew_v0", frames[0].val, 32'h1234);
            check("rew_v1", frames[1].val, 32'hABCD);
        end

        clear_logs();
        wr_word(0, 16'h1234);
        repeat (33) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_sync", sync_n, 2'b11);
        check("abort_clk", dclk, 1'b1);
        check("abort_data", ddata, 1'b0);
        check("abort_busy", busy, 1'b0);
        @(negedge clk);
        frames.delete();
        rd(1, r);
        check("abort_word", r, 8'h00);
        wr(5, 8'h77);
        rd(5, r);
        check("ign_rd5", r, 8'h00);
        rd(4, r);
        check("ign_status", r, 8'h00);
        repeat (200) @(negedge clk);
        check("abort_nframes", frames.size(), 0);

        clear_logs();
        base = frames_done;
        wr(0, 8'h11);
        wr(2, 8'h33);
        wr(1, 8'h22);
        wr(3, 8'h44);
        wait_idle();
        check("ldac_nframes", frames.size(), 2);
`ifdef DAC_SPI_LDAC_EN
        check("ldac_npulse", pulses.size(), 1);
        if (pulses.size() == 1) begin
            check("ldac_len", pulses[0], DIV);
            check("ldac_after", pulse_done[0] - base, 2);
            check("ldac_dist", pulse_dist[0] >= GAPC, 1'b1);
        end
`else
        check("ldac_npulse", pulses.size(), 0);
        check("ldac_const", ldac_n, 1'b1);
`endif

        for (int it = 0; it < 16; it++) begin
            clear_logs();
            exp_ch.delete();
            sel = $urandom_range(1, (1 << CH) - 1);
            do first = $urandom_range(0, CH - 1); while (!sel[first]);
            for (int c = 0; c < CH; c++) v[c] = 16'($urandom);
            wr_word(first, v[first]);
            exp_ch.push_back(first);
            for (int k = 1; k < CH; k++) begin
                int c;
                c = (first + k) % CH;
                if (sel[c]) begin
                    wr_word(c, v[c]);
                    exp_ch.push_back(c);
                end
            end
            wait_idle();
            check("rnd_n", frames.size(), exp_ch.size());
            if (frames.size() == exp_ch.size()) begin
                foreach (exp_ch[i]) begin
                    check("rnd_ch", frames[i].ch, exp_ch[i]);
                    check("rnd_val", frames[i].val, {16'h0, v[exp_ch[i]]});
                    check("rnd_falls", frames[i].nf, WB);
                end
            end
            bad = 0;
            foreach (gaps[i]) if (gaps[i] < GAPC + 1) bad++;
            check("rnd_gap", bad, 0);
            rd(first * 2 + 1, r);
            check("rnd_rb", r, v[first][15:8]);
        end

        check("data_edge", dviol, 0);
        check("one_sync", multi, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end
endmodule
